// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: buffers stage-3 branch resolutions in a FIFO drained during
// non-stall cycles, and runs a full-table invalidate sweep that takes priority.
module btb_update_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       memory_stall,
    input  logic                       res_valid,
    input  logic [PC_W-1:0]            res_pc,
    input  logic                       res_taken,
    input  logic [PC_W-1:0]            res_target,
    input  logic                       inval_req,
    output logic                       upd_valid,
    output logic [PC_W-1:0]            upd_pc,
    output logic                       upd_taken,
    output logic [PC_W-1:0]            upd_target,
    output logic                       inv_valid,
    output logic [IDX_W-1:0]           inv_idx,
    output logic                       inval_busy,
    output logic                       q_full,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] INVAL = 1'b1;

    logic [0:0]       state;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [IDX_W-1:0] sweep;

    logic [PC_W-1:0]  pc_mem     [DEPTH];
    logic             taken_mem  [DEPTH];
    logic [PC_W-1:0]  target_mem [DEPTH];

    logic in_idle;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        in_idle    = (state == IDLE);
        q_full     = (q_count == FULL_CNT);
        pop        = in_idle && !memory_stall && (q_count != '0);
        // A full queue still accepts a push when the head leaves in the same cycle.
        push       = in_idle && res_valid && !inval_req && (!q_full || pop);
        drop       = in_idle && res_valid && !inval_req && q_full && !pop;
        upd_valid  = pop;
        upd_pc     = pc_mem[rd_ptr];
        upd_taken  = taken_mem[rd_ptr];
        upd_target = target_mem[rd_ptr];
        inv_valid  = !in_idle && !memory_stall;
        inv_idx    = sweep;
        inval_busy = !in_idle;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]     <= res_pc;
            taken_mem[wr_ptr]  <= res_taken;
            target_mem[wr_ptr] <= res_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            q_count  <= '0;
            sweep    <= '0;
            drop_cnt <= '0;
        end else if (in_idle) begin
            if (inval_req) begin
                // Flush discards queued updates without counting them as drops.
                state   <= INVAL;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                q_count <= '0;
                sweep   <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)
                    q_count <= q_count + (PTR_W+1)'(1);
                else if (pop && !push)
                    q_count <= q_count - (PTR_W+1)'(1);
                if (drop && (drop_cnt != '1))
                    drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end else begin
            if (inval_req) begin
                sweep <= '0;
            end else if (!memory_stall) begin
                sweep <= sweep + IDX_W'(1);
                if (sweep == '1) state <= IDLE;
            end
        end
    end

endmodule
